feat_bram_stream_reader: RTL and testbench

- Reads the new-feature BRAM (port B) that the GAT core fills, and streams its words to the host side as a valid/ready stream with last marking.
- Sits beside the GAT top wrapper. It drives the byte-addressed feat_bram_addrb port and consumes feat_bram_dout, so the host no longer polls addresses.
- Generates word reads with 1-cycle BRAM latency. A small skid FIFO absorbs downstream backpressure without losing in-flight reads.

---
 rtl/feat_bram_stream_reader.sv | 206 ++++++++++++++++++++
 tb/tb_feat_bram_stream_reader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feat_bram_stream_reader.sv
// Streams the GAT new-feature BRAM (port B) to the host as a valid/ready stream with last marking.
// Define FEAT_RD_NODE_MARK_EN to flag the last feature of every node on m_tuser.
module feat_bram_stream_reader #(
    parameter int unsigned NEW_FEATURE_WIDTH  = 32,
    parameter int unsigned NUM_SUBGRAPHS      = 2708,
    parameter int unsigned NUM_FEATURE_OUT    = 16,
    parameter int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int unsigned FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic                          m_tuser,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned LEN_W = NEW_FEATURE_ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(NEW_FEATURE_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                       state;
    logic [LEN_W-1:0]             len;
    logic [LEN_W-1:0]             issued;
    logic [LEN_W-1:0]             beats;
    logic                         inflight;
    logic                         pend_last;
    logic [CNT_W-1:0]             count;
    logic [NEW_FEATURE_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                         fifo_last [FIFO_DEPTH];

    logic [LEN_W-1:0]             len_sat_c;
    logic [LEN_W-1:0]             issued_inc_c;
    logic [CNT_W:0]               occupancy_c;
    logic                         issue_c;
    logic                         pop_c;

    // Credit check: a read may only issue if its data is guaranteed a FIFO slot.
    assign len_sat_c    = (num_words > DEPTH_LEN) ? DEPTH_LEN : num_words;
    assign issued_inc_c = issued + LEN_W'(1);
    assign occupancy_c  = (CNT_W+1)'(count) + (CNT_W+1)'(inflight);
    assign issue_c      = (state == READ) && (issued != len) &&
                          (occupancy_c < (CNT_W+1)'(FIFO_DEPTH));
    assign pop_c        = m_tvalid && m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            len             <= '0;
            issued          <= '0;
            beats           <= '0;
            inflight        <= 1'b0;
            pend_last       <= 1'b0;
            feat_bram_addrb <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= 1'b0;
            if (pop_c) begin
                beats <= beats + LEN_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len   <= len_sat_c;
                        beats <= '0;
                        busy  <= 1'b1;
                        if (len_sat_c == '0) begin
                            issued <= '0;
                            state  <= DONE;
                        end else begin
                            // Word 0 issues on the accepting edge to keep start-to-valid at 2 cycles.
                            feat_bram_addrb <= '0;
                            issued          <= LEN_W'(1);
                            inflight        <= 1'b1;
                            pend_last       <= (len_sat_c == LEN_W'(1));
                            state           <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue_c) begin
                        feat_bram_addrb <= {issued[NEW_FEATURE_ADDR_W-1:0], 2'b00};
                        issued          <= issued_inc_c;
                        inflight        <= 1'b1;
                        pend_last       <= (issued_inc_c == len);
                    end
                    if ((issue_c ? issued_inc_c : issued) == len) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((count == '0) && !inflight && (beats == len)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FEAT_RD_NODE_MARK_EN
    localparam int unsigned FEAT_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
    localparam logic [FEAT_W-1:0] FEAT_LAST = FEAT_W'(NUM_FEATURE_OUT - 1);

    logic [FEAT_W-1:0] feat_cnt;
    logic              pend_user;
    logic              fifo_user [FIFO_DEPTH];
    logic              user_nxt_c [FIFO_DEPTH];
    logic              accept_c;

    assign accept_c = (state == IDLE) && start && (len_sat_c != '0);

    // Feature index of the next word to issue; word 0 issues on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_cnt  <= '0;
            pend_user <= 1'b0;
        end else if (accept_c) begin
            pend_user <= (FEAT_LAST == '0);
            feat_cnt  <= (FEAT_LAST == '0) ? '0 : FEAT_W'(1);
        end else if (issue_c) begin
            pend_user <= (feat_cnt == FEAT_LAST);
            feat_cnt  <= (feat_cnt == FEAT_LAST) ? '0 : feat_cnt + FEAT_W'(1);
        end
    end
`endif

    logic [NEW_FEATURE_WIDTH-1:0] data_nxt_c [FIFO_DEPTH];
    logic                         last_nxt_c [FIFO_DEPTH];
    logic [CNT_W-1:0]             count_nxt_c;
    logic [IDX_W-1:0]             wr_idx_c;

    // Shift-register skid FIFO: entry 0 is the head and directly drives the stream outputs.
    always_comb begin
        for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
            data_nxt_c[i] = pop_c ? fifo_data[i+1] : fifo_data[i];
            last_nxt_c[i] = pop_c ? fifo_last[i+1] : fifo_last[i];
        end
        data_nxt_c[FIFO_DEPTH-1] = pop_c ? '0 : fifo_data[FIFO_DEPTH-1];
        last_nxt_c[FIFO_DEPTH-1] = pop_c ? 1'b0 : fifo_last[FIFO_DEPTH-1];
`ifdef FEAT_RD_NODE_MARK_EN
        for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
            user_nxt_c[i] = pop_c ? fifo_user[i+1] : fifo_user[i];
        end
        user_nxt_c[FIFO_DEPTH-1] = pop_c ? 1'b0 : fifo_user[FIFO_DEPTH-1];
`endif
        wr_idx_c = IDX_W'(count - CNT_W'(pop_c));
        if (inflight) begin
            data_nxt_c[wr_idx_c] = feat_bram_dout;
            last_nxt_c[wr_idx_c] = pend_last;
`ifdef FEAT_RD_NODE_MARK_EN
            user_nxt_c[wr_idx_c] = pend_user;
`endif
        end
        count_nxt_c = count + CNT_W'(inflight) - CNT_W'(pop_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
`ifdef FEAT_RD_NODE_MARK_EN
                fifo_user[i] <= 1'b0;
`endif
            end
            count    <= '0;
            m_tvalid <= 1'b0;
        end else begin
            fifo_data <= data_nxt_c;
            fifo_last <= last_nxt_c;
`ifdef FEAT_RD_NODE_MARK_EN
            fifo_user <= user_nxt_c;
`endif
            count     <= count_nxt_c;
            m_tvalid  <= (count_nxt_c != '0);
        end
    end

    assign m_tdata = fifo_data[0];
    assign m_tlast = fifo_last[0];
`ifdef FEAT_RD_NODE_MARK_EN
    assign m_tuser = fifo_user[0];
`else
    assign m_tuser = 1'b0;
`endif

endmodule

// File: tb/tb_feat_bram_stream_reader.sv
// Self-checking bench for feat_bram_stream_reader: randomized backpressure and BRAM contents
// checked against a stream model derived from the transfer length and word index.
module tb_feat_bram_stream_reader;

    localparam int DEPTH   = 43328;
    localparam int NFEAT   = 16;
    localparam int FIFO_D  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [16:0] num_words;
    logic [17:0] feat_bram_addrb;
    logic [31:0] feat_bram_dout;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic        busy;
    logic        done;

    logic [31:0] salt;
    int n_cmp = 0;
    int n_fail = 0;

    int r_beats, r_dones, r_first_valid, r_last_beat, r_done_cyc, r_busy_cyc;
    int r_issued, r_tlast_cnt, r_tuser_cnt;

    feat_bram_stream_reader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .num_words       (num_words),
        .feat_bram_addrb (feat_bram_addrb),
        .feat_bram_dout  (feat_bram_dout),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tlast         (m_tlast),
        .m_tuser         (m_tuser),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // BRAM content: word index scrambled by a per-test salt.
    assign feat_bram_dout = 32'(feat_bram_addrb[17:2]) ^ salt;

    // mode 0: ready always high; 1: toggling with a 10-cycle low window; 2: random ~70% high.
    // abort_at >= 0 asserts reset once that many beats were accepted; restart_cyc pulses start while busy.
    task automatic run_transfer(input int n, input int mode, input int abort_at, input int restart_cyc);
        int exp_len, budget, tail;
        logic        stalled, exp_last, exp_user;
        logic [31:0] prev_data, exp_data;
        logic        prev_last;
        logic [17:0] prev_addr, addr_before;
        exp_len = (n > DEPTH) ? DEPTH : n;
        budget  = (mode == 0) ? exp_len + 60 : 4 * exp_len + 200;
        r_beats = 0; r_dones = 0; r_first_valid = -1; r_last_beat = -1; r_done_cyc = -1;
        r_busy_cyc = 0; r_issued = 0; r_tlast_cnt = 0; r_tuser_cnt = 0;
        tail = 0; stalled = 1'b0; prev_data = '0; prev_last = 1'b0;
        addr_before = feat_bram_addrb; prev_addr = feat_bram_addrb;
        @(negedge clk);
        num_words = 17'(n);
        start     = 1'b1;
        m_tready  = (mode != 2) ? 1'b1 : 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == restart_cyc) begin
                start     = 1'b1;
                num_words = 17'd3;
            end
            if (stalled) begin
                n_cmp++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc=%0d: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                             cyc, m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
                end
            end
            if (abort_at >= 0 && r_beats == abort_at) begin
                rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({feat_bram_addrb, m_tdata, m_tvalid, m_tlast, m_tuser, busy, done} !== '0) begin
                    n_fail++;
                    $display("FAIL async_reset: got addr=%h data=%h valid=%b last=%b user=%b busy=%b done=%b, want all 0",
                             feat_bram_addrb, m_tdata, m_tvalid, m_tlast, m_tuser, busy, done);
                end
                return;
            end
            if (m_tvalid && r_first_valid < 0) r_first_valid = cyc;
            if (busy) r_busy_cyc++;
            if (done) begin
                r_dones++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_at_done: got busy=%b, want 0", busy);
                end
            end
            if (exp_len > 0) begin
                if (cyc == 1) begin
                    n_cmp++;
                    if (feat_bram_addrb !== 18'd0) begin
                        n_fail++;
                        $display("FAIL addr_first: got %h, want 0", feat_bram_addrb);
                    end
                    r_issued = 1;
                end else if (feat_bram_addrb !== prev_addr) begin
                    n_cmp++;
                    if (feat_bram_addrb !== 18'(4 * r_issued)) begin
                        n_fail++;
                        $display("FAIL addr_step: got %h, want %h", feat_bram_addrb, 18'(4 * r_issued));
                    end
                    r_issued++;
                end
                n_cmp++;
                if (r_issued - r_beats > FIFO_D + 1) begin
                    n_fail++;
                    $display("FAIL occupancy cyc=%0d: got %0d outstanding, want <= %0d",
                             cyc, r_issued - r_beats, FIFO_D + 1);
                end
            end else begin
                n_cmp++;
                if (feat_bram_addrb !== addr_before) begin
                    n_fail++;
                    $display("FAIL addr_hold: got %h, want %h", feat_bram_addrb, addr_before);
                end
            end
            prev_addr = feat_bram_addrb;
            case (mode)
                0:       m_tready = 1'b1;
                1:       m_tready = (cyc >= 15 && cyc < 25) ? 1'b0 : cyc[0];
                default: m_tready = ($urandom_range(0, 99) < 70);
            endcase
            if (m_tvalid && m_tready) begin
                exp_data = 32'(r_beats) ^ salt;
                exp_last = (r_beats == exp_len - 1);
`ifdef FEAT_RD_NODE_MARK_EN
                exp_user = ((r_beats % NFEAT) == NFEAT - 1);
`else
                exp_user = 1'b0;
`endif
                n_cmp++;
                if (r_beats >= exp_len || m_tdata !== exp_data || m_tlast !== exp_last || m_tuser !== exp_user) begin
                    n_fail++;
                    $display("FAIL beat[%0d]: got data=%h last=%b user=%b, want data=%h last=%b user=%b (len %0d)",
                             r_beats, m_tdata, m_tlast, m_tuser, exp_data, exp_last, exp_user, exp_len);
                end
                if (m_tlast) r_tlast_cnt++;
                if (m_tuser) r_tuser_cnt++;
                r_beats++;
                r_last_beat = cyc;
            end
            stalled   = m_tvalid && !m_tready;
            prev_data = m_tdata;
            prev_last = m_tlast;
            if (r_dones > 0) begin
                tail++;
                if (tail > 3) break;
            end
        end
        m_tready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; num_words = '0; m_tready = 1'b0; salt = '0;
        @(negedge clk);
        n_cmp++;
        if ({feat_bram_addrb, m_tdata, m_tvalid, m_tlast, m_tuser, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got addr=%h data=%h valid=%b last=%b user=%b busy=%b done=%b, want all 0",
                     feat_bram_addrb, m_tdata, m_tvalid, m_tlast, m_tuser, busy, done);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({m_tvalid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_quiet: got valid=%b busy=%b done=%b, want 0 0 0", m_tvalid, busy, done);
        end
    endtask

    task automatic test_basic;
        salt = '0;
        run_transfer(32, 0, -1, -1);
        n_cmp++;
        if (r_beats != 32 || r_dones != 1 || r_tlast_cnt != 1) begin
            n_fail++;
            $display("FAIL basic_counts: got beats=%0d dones=%0d lasts=%0d, want 32 1 1", r_beats, r_dones, r_tlast_cnt);
        end
        n_cmp++;
        if (r_first_valid != 2) begin
            n_fail++;
            $display("FAIL basic_latency: got first valid at cycle %0d, want 2", r_first_valid);
        end
        n_cmp++;
        if (r_last_beat - r_first_valid != 31) begin
            n_fail++;
            $display("FAIL basic_throughput: got %0d cycles for 32 beats, want 32", r_last_beat - r_first_valid + 1);
        end
        n_cmp++;
        if (r_issued != 32 || feat_bram_addrb !== 18'h7C) begin
            n_fail++;
            $display("FAIL basic_addr: got %0d reads, final addr %h, want 32 and 7c", r_issued, feat_bram_addrb);
        end
    endtask

    task automatic test_backpressure;
        salt = $urandom;
        run_transfer(40, 1, -1, 5);
        n_cmp++;
        if (r_beats != 40 || r_dones != 1 || r_tlast_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_counts: got beats=%0d dones=%0d lasts=%0d, want 40 1 1", r_beats, r_dones, r_tlast_cnt);
        end
    endtask

    task automatic test_zero_len;
        run_transfer(0, 0, -1, -1);
        n_cmp++;
        if (r_beats != 0 || r_first_valid != -1) begin
            n_fail++;
            $display("FAIL zero_beats: got beats=%0d first_valid=%0d, want 0 -1", r_beats, r_first_valid);
        end
        n_cmp++;
        if (r_dones != 1 || r_done_cyc != 2 || r_busy_cyc != 1) begin
            n_fail++;
            $display("FAIL zero_timing: got dones=%0d done_cyc=%0d busy_cycles=%0d, want 1 2 1",
                     r_dones, r_done_cyc, r_busy_cyc);
        end
    endtask

    task automatic test_saturate;
        salt = $urandom;
        run_transfer(50000, 0, -1, -1);
        n_cmp++;
        if (r_beats != DEPTH || r_dones != 1 || r_tlast_cnt != 1) begin
            n_fail++;
            $display("FAIL saturate: got beats=%0d dones=%0d lasts=%0d, want %0d 1 1",
                     r_beats, r_dones, r_tlast_cnt, DEPTH);
        end
    endtask

    task automatic test_reset_mid;
        salt = $urandom;
        run_transfer(32, 0, 10, -1);
        n_cmp++;
        if (r_dones != 0 || r_beats != 10) begin
            n_fail++;
            $display("FAIL abort: got dones=%0d beats=%0d, want 0 10", r_dones, r_beats);
        end
        @(negedge clk);
        rst_n = 1'b1;
        salt = $urandom;
        run_transfer(5, 2, -1, -1);
        n_cmp++;
        if (r_beats != 5 || r_dones != 1) begin
            n_fail++;
            $display("FAIL after_abort: got beats=%0d dones=%0d, want 5 1", r_beats, r_dones);
        end
    endtask

    task automatic test_node_mark;
        int exp_marks;
`ifdef FEAT_RD_NODE_MARK_EN
        exp_marks = 3;
`else
        exp_marks = 0;
`endif
        salt = $urandom;
        run_transfer(48, 2, -1, -1);
        n_cmp++;
        if (r_tuser_cnt != exp_marks || r_beats != 48) begin
            n_fail++;
            $display("FAIL node_mark: got marks=%0d beats=%0d, want %0d 48", r_tuser_cnt, r_beats, exp_marks);
        end
    endtask

    task automatic test_random;
        int n;
        for (int k = 0; k < 7; k++) begin
            n = (k == 0) ? 1 : int'($urandom_range(1, 120));
            salt = $urandom;
            run_transfer(n, 2, -1, -1);
            n_cmp++;
            if (r_beats != n || r_dones != 1 || r_tlast_cnt != 1) begin
                n_fail++;
                $display("FAIL random[%0d] n=%0d: got beats=%0d dones=%0d lasts=%0d, want %0d 1 1",
                         k, n, r_beats, r_dones, r_tlast_cnt, n);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_zero_len;
        test_saturate;
        test_reset_mid;
        test_node_mark;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
